// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing derivations and receiver state encoding.
// Used by both the receiver and the transmitter.
package ws2812_pkg;

   localparam int DATA_W = 24;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } rx_state_t;

   // Receive thresholds, all in system clock cycles
   function automatic int t_thresh(input int clk_mhz);
      return clk_mhz * 625 / 1000;
   endfunction

   function automatic int t_high_max(input int clk_mhz);
      return clk_mhz * 2;
   endfunction

   function automatic int t_gap(input int clk_mhz);
      return clk_mhz * 50;
   endfunction

   // Transmit bit timing: 1.25 us period, 0.35 us / 0.70 us high time
   function automatic int tx_period(input int clk_mhz);
      return clk_mhz * 1250 / 1000;
   endfunction

   function automatic int tx_t0h(input int clk_mhz);
      return clk_mhz * 350 / 1000;
   endfunction

   function automatic int tx_t1h(input int clk_mhz);
      return clk_mhz * 700 / 1000;
   endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the asynchronous WS2812 line plus a delay
// register used to derive single-cycle rise/fall strobes.
module ws2812_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic s2,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s3;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: decodes high-time modulated bits into 24-bit
// words, numbers them per frame and flags frame gaps and protocol errors.
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int CLK_MHZ  = 12,
   parameter int NUM_LEDS = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              din,
   output logic [DATA_W-1:0] rgb_data,
   output logic [7:0]        led_num,
   output logic              valid,
   output logic              frame_done,
   output logic              error
);

   localparam int T_THRESH   = t_thresh(CLK_MHZ);
   localparam int T_HIGH_MAX = t_high_max(CLK_MHZ);
   localparam int T_GAP      = t_gap(CLK_MHZ);

   localparam int HW = $clog2(T_HIGH_MAX + 1);
   localparam int LW = $clog2(T_GAP + 1);
   localparam int BW = $clog2(DATA_W + 1);
   localparam int WW = $clog2(NUM_LEDS + 1);

   localparam logic [HW-1:0] HIGH_ONE   = HW'(1);
   localparam logic [HW-1:0] HIGH_THR   = HW'(T_THRESH);
   localparam logic [HW-1:0] HIGH_LAST  = HW'(T_HIGH_MAX - 1);
   localparam logic [LW-1:0] GAP_FULL   = LW'(T_GAP);
   localparam logic [LW-1:0] GAP_LAST   = LW'(T_GAP - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
   localparam logic [WW-1:0] WORD_MAX   = WW'(NUM_LEDS);
   localparam logic [7:0]    LED_TOP    = 8'(NUM_LEDS - 1);

   logic s2;
   logic rise;
   logic fall;

   rx_state_t         state,    state_nx;
   logic [HW-1:0]     high_cnt, high_cnt_nx;
   logic [LW-1:0]     low_cnt,  low_cnt_nx;
   logic [BW-1:0]     bit_cnt,  bit_cnt_nx;
   logic [WW-1:0]     word_cnt, word_cnt_nx;
   logic [DATA_W-1:0] shreg,    shreg_nx;
   logic [DATA_W-1:0] rgb_data_nx;
   logic [7:0]        led_num_nx;
   logic              valid_nx;
   logic              frame_done_nx;
   logic              error_nx;

   ws2812_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (din),
      .s2    (s2),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_SYNC;
         high_cnt   <= '0;
         low_cnt    <= '0;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         shreg      <= '0;
         rgb_data   <= '0;
         led_num    <= '0;
         valid      <= 1'b0;
         frame_done <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_nx;
         high_cnt   <= high_cnt_nx;
         low_cnt    <= low_cnt_nx;
         bit_cnt    <= bit_cnt_nx;
         word_cnt   <= word_cnt_nx;
         shreg      <= shreg_nx;
         rgb_data   <= rgb_data_nx;
         led_num    <= led_num_nx;
         valid      <= valid_nx;
         frame_done <= frame_done_nx;
         error      <= error_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      high_cnt_nx   = high_cnt;
      low_cnt_nx    = low_cnt;
      bit_cnt_nx    = bit_cnt;
      word_cnt_nx   = word_cnt;
      shreg_nx      = shreg;
      rgb_data_nx   = rgb_data;
      led_num_nx    = led_num;
      valid_nx      = 1'b0;
      frame_done_nx = 1'b0;
      error_nx      = 1'b0;

      unique case (state)
         // Wait for a clean gap before trusting any bit boundaries
         ST_SYNC: begin
            if (s2) begin
               low_cnt_nx = '0;
            end else if (low_cnt == GAP_LAST) begin
               low_cnt_nx  = GAP_FULL;
               bit_cnt_nx  = '0;
               word_cnt_nx = '0;
               state_nx    = ST_LOW;
            end else begin
               low_cnt_nx = low_cnt + 1'b1;
            end
         end

         ST_LOW: begin
            if (rise) begin
               high_cnt_nx = HIGH_ONE;
               state_nx    = ST_HIGH;
            end else if (low_cnt != GAP_FULL) begin
               low_cnt_nx = low_cnt + 1'b1;
               if (low_cnt == GAP_LAST) begin
                  frame_done_nx = (bit_cnt != '0) || (word_cnt != '0);
                  error_nx      = (bit_cnt != '0);
                  bit_cnt_nx    = '0;
                  word_cnt_nx   = '0;
               end
            end
         end

         ST_HIGH: begin
            if (fall) begin
               shreg_nx   = {shreg[DATA_W-2:0], (high_cnt >= HIGH_THR)};
               low_cnt_nx = '0;
               state_nx   = ST_LOW;
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt_nx = '0;
                  // Words beyond the frame length are dropped and flagged
                  if (word_cnt < WORD_MAX) begin
                     rgb_data_nx = shreg_nx;
                     led_num_nx  = LED_TOP - 8'(word_cnt);
                     valid_nx    = 1'b1;
                     word_cnt_nx = word_cnt + 1'b1;
                  end else begin
                     error_nx = 1'b1;
                  end
               end else begin
                  bit_cnt_nx = bit_cnt + 1'b1;
               end
            end else if (high_cnt == HIGH_LAST) begin
               error_nx    = 1'b1;
               high_cnt_nx = '0;
               low_cnt_nx  = '0;
               bit_cnt_nx  = '0;
               state_nx    = ST_SYNC;
            end else begin
               high_cnt_nx = high_cnt + 1'b1;
            end
         end

         default: state_nx = ST_SYNC;
      endcase
   end

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: directed pulse trains push expected
// strobes into a queue that an independent monitor drains and compares.
module tb_ws2812_rx;
   import ws2812_pkg::*;

   localparam int CLK_MHZ  = 12;
   localparam int NUM_LEDS = 8;
   localparam int PER      = tx_period(CLK_MHZ);
   localparam int T0H      = tx_t0h(CLK_MHZ);
   localparam int T1H      = tx_t1h(CLK_MHZ);

   localparam logic [2:0] K_VALID    = 3'b100;
   localparam logic [2:0] K_DONE     = 3'b010;
   localparam logic [2:0] K_ERR      = 3'b001;
   localparam logic [2:0] K_DONE_ERR = 3'b011;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        din = 1'b0;
   logic [23:0] rgb_data;
   logic [7:0]  led_num;
   logic        valid;
   logic        frame_done;
   logic        error;

   typedef struct {
      logic [2:0]  kind;
      logic [23:0] data;
      logic [7:0]  led;
   } exp_t;

   exp_t sb[$];
   int   asserts = 0;
   int   fails   = 0;
   logic [23:0] tx_mem [NUM_LEDS];

   ws2812_rx #(.CLK_MHZ(CLK_MHZ), .NUM_LEDS(NUM_LEDS)) dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .rgb_data   (rgb_data),
      .led_num    (led_num),
      .valid      (valid),
      .frame_done (frame_done),
      .error      (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [2:0] k, input logic [23:0] d, input logic [7:0] l);
      exp_t e;
      e.kind = k;
      e.data = d;
      e.led  = l;
      sb.push_back(e);
   endtask

   task automatic hold(input logic lvl, input int n);
      din = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int hi, input int lo);
      hold(1'b1, hi);
      hold(1'b0, lo);
   endtask

   task automatic send_bit(input logic b);
      if (b) pulse(T1H, PER - T1H);
      else   pulse(T0H, PER - T0H);
   endtask

   task automatic send_bits(input logic [23:0] w, input int n);
      for (int i = 0; i < n; i++) send_bit(w[23-i]);
   endtask

   task automatic gap();
      hold(1'b0, 700);
   endtask

   // Monitor: every strobe must match the next queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && (valid || frame_done || error)) begin
            if (sb.size() == 0) begin
               asserts++;
               fails++;
               $display("FAIL unexpected_event: got v=%0b d=%0b e=%0b, expected none at %0t",
                        valid, frame_done, error, $time);
            end else begin
               e = sb.pop_front();
               check("event_kind", {29'd0, valid, frame_done, error}, {29'd0, e.kind});
               if (valid) begin
                  check("rgb_data", {8'd0, rgb_data}, {8'd0, e.data});
                  check("led_num", {24'd0, led_num}, {24'd0, e.led});
               end
            end
         end
      end
   end

   initial begin
      int lat;

      // Reset state
      repeat (4) @(negedge clk);
      check("rst_rgb", {8'd0, rgb_data}, 32'd0);
      check("rst_led", {24'd0, led_num}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_done", {31'd0, frame_done}, 32'd0);
      check("rst_err", {31'd0, error}, 32'd0);
      reset = 1'b0;
      gap();

      // Loopback frame: index 7 is transmitted first
      for (int i = 0; i < NUM_LEDS; i++) tx_mem[i] = 24'(i + 1);
      for (int i = NUM_LEDS - 1; i >= 0; i--) push(K_VALID, tx_mem[i], 8'(i));
      push(K_DONE, 24'd0, 8'd0);
      for (int i = NUM_LEDS - 1; i >= 0; i--) send_bits(tx_mem[i], 24);
      gap();

      // Threshold boundary: 6 -> 0, 7 -> 1, 1-cycle low spacer
      push(K_VALID, 24'h555555, 8'd7);
      push(K_VALID, 24'h000000, 8'd6);
      push(K_VALID, 24'hFFFFFF, 8'd5);
      push(K_DONE, 24'd0, 8'd0);
      for (int i = 0; i < 23; i++) pulse((i % 2) ? 7 : 6, 1);
      hold(1'b1, 7);
      din = 1'b0;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (valid && lat == 0) lat = k;
      end
      check("valid_latency", lat, 3);
      for (int i = 0; i < 24; i++) pulse(6, 1);
      for (int i = 0; i < 24; i++) pulse(7, 1);
      gap();

      // Stuck high, then pulses ignored until a fresh gap
      push(K_ERR, 24'd0, 8'd0);
      hold(1'b1, 30);
      hold(1'b0, 20);
      send_bits(24'hABCDEF, 24);
      gap();

      // Partial word: frame_done and error together
      push(K_DONE_ERR, 24'd0, 8'd0);
      send_bits(24'h3FF000, 10);
      gap();

      // Overflow: ninth word dropped with error
      for (int i = 0; i < NUM_LEDS; i++) push(K_VALID, 24'hA00000 + 24'(i), 8'(NUM_LEDS - 1 - i));
      push(K_ERR, 24'd0, 8'd0);
      push(K_DONE, 24'd0, 8'd0);
      for (int i = 0; i < NUM_LEDS + 1; i++) send_bits(24'hA00000 + 24'(i), 24);
      gap();

      // Reset mid-word: silent until a full gap, then decodes again
      send_bits(24'hC3C3C3, 12);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_rgb", {8'd0, rgb_data}, 32'd0);
      check("midrst_led", {24'd0, led_num}, 32'd0);
      check("midrst_valid", {31'd0, valid}, 32'd0);
      reset = 1'b0;
      send_bits(24'hC3C3C3, 12);
      send_bits(24'h123456, 24);
      gap();
      push(K_VALID, 24'h654321, 8'd7);
      push(K_DONE, 24'd0, 8'd0);
      send_bits(24'h654321, 24);
      gap();

      repeat (20) @(negedge clk);
      check("sb_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
